// File: rtl/seq_arith_pkg.sv
// Shared types and helpers for the sequential arithmetic blocks.
package seq_arith_pkg;

  // Default operand width and the iteration-counter width that goes with it.
  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  // Widest operand abs_u handles; callers sign-extend into it and truncate back.
  localparam int ABS_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_t;

  // Unsigned magnitude of a two's-complement value. The most negative input
  // maps to 2^(n-1), which still fits once truncated back to n bits unsigned.
  function automatic logic [ABS_W-1:0] abs_u(input logic [ABS_W-1:0] v);
    return v[ABS_W-1] ? -v : v;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder and subtract the divisor when it fits.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             q_msb,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  // The partial remainder is always below divisor_mag <= 2^(WIDTH-1), so its
  // top bit is zero and the left shift never loses information.
  logic [WIDTH-1:0] rem_t;

  assign rem_t = {rem[WIDTH-2:0], q_msb};

  // Compare-and-subtract; a set quotient bit means the subtraction was kept.
  always_comb begin
    q_bit    = 1'b0;
    rem_next = rem_t;
    if (rem_t >= divisor_mag) begin
      q_bit    = 1'b1;
      rem_next = rem_t - divisor_mag;
    end
  end

endmodule

// File: rtl/sequential_divider.sv
// Signed restoring divider, one quotient bit per clock, start/busy/done handshake.
// Quotient truncates toward zero; remainder takes the sign of the dividend.
// Optional macro SEQ_DIV_EARLY_EXIT_EN: when |dividend| < |divisor| the result
// is known at load time and the CALC phase is skipped (same results, lower latency).
module sequential_divider
  import seq_arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH  // 4..ABS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] q_reg;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] rem_reg;    // partial remainder
  logic [WIDTH-1:0] dvs_mag;
  logic             sign_q, sign_r, zero_div;

  logic [WIDTH-1:0] dvd_mag_in, dvs_mag_in, rem_next;
  logic             divisor_zero, early_exit, q_bit;

  assign dvd_mag_in   = WIDTH'(abs_u(ABS_W'($signed(dividend))));
  assign dvs_mag_in   = WIDTH'(abs_u(ABS_W'($signed(divisor))));
  assign divisor_zero = (divisor == '0);

`ifdef SEQ_DIV_EARLY_EXIT_EN
  assign early_exit = !divisor_zero && (dvd_mag_in < dvs_mag_in);
`else
  assign early_exit = 1'b0;
`endif

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_reg),
    .q_msb       (q_reg[WIDTH-1]),
    .divisor_mag (dvs_mag),
    .rem_next    (rem_next),
    .q_bit       (q_bit)
  );

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and status decode; start is only looked at in IDLE.
  // NOTE: every output is defaulted first so no path through the case infers a latch.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = (divisor_zero || early_exit) ? FIX : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (count == LAST) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load magnitudes and signs, iterate, then apply signs to the outputs.
  // NOTE: all datapath flops are reset, so an aborted op leaves nothing stale behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      q_reg       <= '0;
      rem_reg     <= '0;
      dvs_mag     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sign_q   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r   <= dividend[WIDTH-1];
            dvs_mag  <= dvs_mag_in;
            zero_div <= divisor_zero;
            count    <= '0;
            // On early exit the answer is q = 0, r = |dividend| straight away.
            q_reg    <= early_exit ? '0 : dvd_mag_in;
            rem_reg  <= early_exit ? dvd_mag_in : '0;
          end
        end
        CALC: begin
          q_reg   <= {q_reg[WIDTH-2:0], q_bit};
          rem_reg <= rem_next;
          count   <= count + 1'b1;
        end
        FIX: begin
          div_by_zero <= zero_div;
          if (zero_div) begin
            // q_reg still holds |dividend|; re-applying its sign restores the dividend.
            quotient  <= '1;
            remainder <= sign_r ? -q_reg : q_reg;
          end else begin
            quotient  <= sign_q ? -q_reg : q_reg;
            remainder <= sign_r ? -rem_reg : rem_reg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// Scoreboard bench for sequential_divider: the driver pushes model results for
// every accepted start, the monitor pops and compares on each done pulse.
module tb_sequential_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  always #5 clk = ~clk;

  sequential_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  typedef struct {
    logic [W-1:0] a, b, q, r;
    logic         dbz;
    int           lat;        // cycles from start edge to done, also busy length
    int           start_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic truncates toward zero and gives the
  // remainder the dividend's sign; narrowing to W bits yields the MIN/-1 wrap.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa, sd, aa, ad;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    e.a = a;
    e.b = b;
    e.start_cyc = 0;
    if (b == '0) begin
      e.q   = '1;
      e.r   = a;
      e.dbz = 1'b1;
      e.lat = 1;
    end else begin
      e.q   = W'(sa / sd);
      e.r   = W'(sa % sd);
      e.dbz = 1'b0;
      e.lat = W + 1;
      aa = (sa < 0) ? -sa : sa;
      ad = (sd < 0) ? -sd : sd;
`ifdef SEQ_DIV_EARLY_EXIT_EN
      if (aa < ad) e.lat = 1;
`else
      if (aa < ad) e.lat = W + 1;
`endif
    end
    return e;
  endfunction

  // Monitor: compare every done pulse against the oldest expected result.
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (sb_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_done: got quotient %0h with no op outstanding", quotient);
        end else begin
          mon_e = sb_q.pop_front();
          check($sformatf("quotient %0d/%0d", $signed(mon_e.a), $signed(mon_e.b)), quotient, mon_e.q);
          check($sformatf("remainder %0d/%0d", $signed(mon_e.a), $signed(mon_e.b)), remainder, mon_e.r);
          check($sformatf("div_by_zero %0d/%0d", $signed(mon_e.a), $signed(mon_e.b)), div_by_zero, mon_e.dbz);
          check($sformatf("latency %0d/%0d", $signed(mon_e.a), $signed(mon_e.b)), cyc - mon_e.start_cyc - 1, mon_e.lat);
          check($sformatf("busy_cycles %0d/%0d", $signed(mon_e.a), $signed(mon_e.b)), busy_cnt, mon_e.lat);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL wait_idle: got busy=%0b done=%0b after 200 cycles, expected idle", busy, done);
    end
  endtask

  // Issue one op from a negedge; operands are scrambled after the start edge
  // so a design that fails to capture them shows up.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_it);
    exp_t e;
    wait_idle();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (expect_it) begin
      e = model(a, b);
      e.start_cyc = cyc;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rand_op(input int mode);
    logic [W-1:0] v;
    case (mode)
      0:       v = $urandom;
      1:       v = W'($urandom_range(0, 2000));
      default: v = W'($urandom_range(0, 20));
    endcase
    if (mode != 0 && $urandom_range(0, 1) == 1) v = -v;
    return v;
  endfunction

  initial begin
    int mode;
    int n;
    logic [W-1:0] a, b;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset_quotient", quotient, '0);
    check("reset_remainder", remainder, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_div_by_zero", div_by_zero, 1'b0);
    reset = 1'b1;
    @(negedge clk);

    // Basic and sign combinations.
    issue(32'd100, 32'd7, 1'b1);
    issue(-32'sd100, 32'd7, 1'b1);
    issue(32'd100, -32'sd7, 1'b1);
    issue(-32'sd100, -32'sd7, 1'b1);

    // Divide by zero, then a normal op clears the flag.
    issue(32'd1234, 32'd0, 1'b1);
    issue(32'd10, 32'd3, 1'b1);
    issue(32'h8000_0000, 32'd0, 1'b1);

    // Overflow and most-negative operands.
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    issue(32'h8000_0000, 32'd1, 1'b1);
    issue(32'd7, 32'h8000_0000, 1'b1);
    issue(32'h8000_0000, 32'h8000_0000, 1'b1);

    // Dividend smaller than divisor (early-exit candidate).
    issue(32'd5, 32'd9, 1'b1);
    issue(-32'sd5, 32'd9, 1'b1);

    // start while busy is ignored.
    issue(32'd100, 32'd7, 1'b1);
    repeat (9) @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);

    // Reset mid-calculation aborts with no done pulse.
    issue(32'd100, 32'd7, 1'b0);
    repeat (19) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_div_by_zero", div_by_zero, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_no_done", done, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    issue(32'd9, 32'd3, 1'b1);

    // Random signed sweep.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: begin a = rand_op(0); b = rand_op(0); end
        1: begin a = rand_op(1); b = rand_op(2); end
        2: begin a = rand_op(0); b = '0; end
        default: begin a = rand_op(2); b = rand_op(1); end
      endcase
      issue(a, b, 1'b1);
    end

    // Drain the scoreboard.
    wait_idle();
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb_q.size());
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
